mrd_stream_loader: RTL

Upstream feeder for the 16-column MRD matrix-inversion array. Accepts a serial element stream with a valid/ready handshake, assembles the DIMENSION×DIMENSION matrix A and the initial-approximation vector M_init, and then drives the array's `en` for a fixed run window. It holds all array operands stable during the run, supplies the constant unit vectors e1..e16, and signals completion.

---
 rtl/mrd_pkg.sv | 33 +++
 rtl/mrd_run_timer.sv | 41 ++++
 rtl/mrd_stream_loader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mrd_pkg.sv
`default_nettype none
// ============================================================================
// mrd_pkg
// Shared constants, state encoding and the identity-vector constant for the
// MRD stream loader.
// Revision: 1.0
// ============================================================================
package mrd_pkg;

  localparam int DIMENSION = 16;
  localparam int WIDTH     = 8;
  localparam int NUM_ELEM  = DIMENSION * DIMENSION + DIMENSION;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Unit vectors e1..eN: row slot i holds e_(i+1), a single 1 at element i.
  // Element 0 of every vector sits in the most significant slot.
  function automatic logic [DIMENSION*DIMENSION*WIDTH-1:0] identity_flat();
    logic [DIMENSION*DIMENSION*WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < DIMENSION; i++) begin
      v[i*DIMENSION*WIDTH + (DIMENSION-1-i)*WIDTH +: WIDTH] = WIDTH'(1);
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mrd_run_timer.sv
`default_nettype none
// ============================================================================
// mrd_run_timer
// Loadable down-counter. 'en' is high for exactly RUN_CYCLES cycles after a
// load; 'tc' flags the last enabled cycle.
// Revision: 1.0
// ============================================================================
module mrd_run_timer #(
  parameter int RUN_CYCLES = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic en,
  output logic tc
);

  localparam int CW = $clog2(RUN_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(RUN_CYCLES);

  logic [CW-1:0] count;

  // Terminal count: the final cycle of the run window.
  assign tc = (count == CW'(1));

  // Count down from the load value; en tracks a non-zero count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      en    <= 1'b0;
    end else if (load) begin
      count <= LOAD_VAL;
      en    <= (RUN_CYCLES > 0);
    end else if (count != '0) begin
      count <= count - 1'b1;
      en    <= (count != CW'(1));
    end
  end

endmodule
`default_nettype wire

// File: rtl/mrd_stream_loader.sv
`default_nettype none
// ============================================================================
// mrd_stream_loader
// Assembles matrix A and vector M_init from a valid/ready element stream,
// then enables the MRD array for a fixed run window and signals completion.
// Revision: 1.0
// ============================================================================
module mrd_stream_loader #(
  parameter int DIMENSION    = mrd_pkg::DIMENSION,
  parameter int WIDTH        = mrd_pkg::WIDTH,
  parameter int ITER_NUM     = 2,
  parameter int CYC_PER_ITER = 20
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic signed [WIDTH-1:0]               s_data,
  input  logic                                  s_last,
  output logic                                  en,
  output logic [DIMENSION*DIMENSION*WIDTH-1:0]  A_flat,
  output logic [DIMENSION*WIDTH-1:0]            M_init,
  output logic [DIMENSION*DIMENSION*WIDTH-1:0]  e_flat,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  import mrd_pkg::*;

  localparam int A_ELEMS    = DIMENSION * DIMENSION;
  localparam int FRAME_LEN  = A_ELEMS + DIMENSION;
  localparam int IDX_W      = $clog2(FRAME_LEN);
  localparam int AI_W       = $clog2(A_ELEMS);
  localparam int MI_W       = $clog2(DIMENSION);
  localparam int RUN_CYCLES = ITER_NUM * CYC_PER_ITER;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] A_LIMIT  = IDX_W'(A_ELEMS);

  state_t           state, state_d;
  logic [IDX_W-1:0] cnt, cnt_d;
  logic             beat;
  logic             wr_en;
  logic             timer_load;
  logic             tc;
  logic             err_d;
  logic             done_d;
  logic [AI_W-1:0]  a_idx;
  logic [MI_W-1:0]  m_idx;

  logic [WIDTH-1:0] a_mem [A_ELEMS];
  logic [WIDTH-1:0] m_mem [DIMENSION];

  assign s_ready = (state == IDLE) || (state == LOAD);
  assign beat    = s_valid && s_ready;
  assign a_idx   = AI_W'(cnt);
  assign m_idx   = MI_W'(cnt - A_LIMIT);
  assign e_flat  = identity_flat();

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next-state decode, framing checks and write/timer strobes.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    wr_en      = 1'b0;
    timer_load = 1'b0;
    err_d      = 1'b0;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (beat) begin
          wr_en = 1'b1;
          // A frame cannot end on its first element.
          if (s_last) begin
            err_d = 1'b1;
          end else begin
            cnt_d   = IDX_W'(1);
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          wr_en = 1'b1;
          if (s_last != (cnt == LAST_IDX)) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt == LAST_IDX) begin
            cnt_d      = '0;
            timer_load = 1'b1;
            state_d    = RUN;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      RUN: begin
        if (tc) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Element counter and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      err  <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      err  <= err_d;
      done <= done_d;
      busy <= (state_d != IDLE);
    end
  end

  // Operand storage: only accepted beats write, so contents freeze in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < A_ELEMS; i++)   a_mem[i] <= '0;
      for (int i = 0; i < DIMENSION; i++) m_mem[i] <= '0;
    end else if (wr_en) begin
      if (cnt < A_LIMIT) a_mem[a_idx] <= s_data;
      else               m_mem[m_idx] <= s_data;
    end
  end

  for (genvar k = 0; k < A_ELEMS; k++) begin : g_a_pack
    assign A_flat[(k / DIMENSION) * DIMENSION * WIDTH
                  + (DIMENSION - 1 - (k % DIMENSION)) * WIDTH +: WIDTH] = a_mem[k];
  end

  for (genvar i = 0; i < DIMENSION; i++) begin : g_m_pack
    assign M_init[(DIMENSION - 1 - i) * WIDTH +: WIDTH] = m_mem[i];
  end

  mrd_run_timer #(
    .RUN_CYCLES (RUN_CYCLES)
  ) u_run_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (en),
    .tc   (tc)
  );

endmodule
`default_nettype wire
